// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    // Requester/consumer side
    modport master (
        output in_valid, a, b, cin, op_sub, res_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, res_valid, sum, cout
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, op_sub, res_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, res_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, registered carry.
// Optional signed-overflow flag compiled in with SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder: WIDTH must be >= 2");
        end
        if (DIGIT < 1) begin : g_bad_digit
            $error("serial_adder: DIGIT must be >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state;
    logic             r_idle;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_res_valid;
    logic [CW-1:0]    r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic [DIGIT-1:0] w_dsum;
    logic             w_dcarry;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_in_fire;

    // One DIGIT-wide full-adder slice on the low digit of the operand shift registers
    always_comb begin
        {w_dcarry, w_dsum} = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                           + {{DIGIT{1'b0}}, r_carry};
    end

    // Result digits enter at the MSB end so the LSB digit lands at bit 0 after N shifts
    generate
        if (DIGIT == WIDTH) begin : g_sum_single
            assign w_sum_next = w_dsum;
        end else begin : g_sum_shift
            assign w_sum_next = {w_dsum, r_sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_in_fire     = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = r_idle & ~rst;
    assign bus.res_valid = r_res_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idle      <= 1'b1;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_sum       <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_res_valid <= 1'b0;
            r_cnt       <= {CW{1'b0}};
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_a     <= bus.a;
                        r_b     <= bus.op_sub ? ~bus.b : bus.b;
                        r_carry <= bus.op_sub ? 1'b1 : bus.cin;
                        r_cnt   <= {CW{1'b0}};
                        r_idle  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= w_sum_next;
                    r_carry <= w_dcarry;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        // Low digits now hold the original MSB digit of A and B'
                        r_cout      <= w_dcarry;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf <= (r_a[DIGIT-1] == r_b[DIGIT-1]) &&
                                 (w_dsum[DIGIT-1] != r_a[DIGIT-1]);
`endif
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_idle      <= 1'b1;
                        r_state     <= S_IDLE;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf       <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_idle      <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
